// File: rtl/game_screen_pkg.sv
// Shared types for the game-flow sequencer: screen states, one-hot select
// codes and default screen durations.
package game_screen_pkg;

  typedef enum logic [2:0] {
    LOGO        = 3'd0,
    GET_READY   = 3'd1,
    PLAY        = 3'd2,
    TIMES_UP    = 3'd3,
    LEADERBOARD = 3'd4
  } screen_state_t;

  localparam int NUM_SCREENS = 5;

  typedef logic [NUM_SCREENS-1:0] screen_sel_t;

  // Bit order matches {leaderboard, times_up, play_active, get_ready, logo}
  localparam screen_sel_t SEL_LOGO        = 5'b00001;
  localparam screen_sel_t SEL_GET_READY   = 5'b00010;
  localparam screen_sel_t SEL_PLAY        = 5'b00100;
  localparam screen_sel_t SEL_TIMES_UP    = 5'b01000;
  localparam screen_sel_t SEL_LEADERBOARD = 5'b10000;

  localparam int DEF_CLK_HZ      = 25_000_000;
  localparam int DEF_READY_SEC   = 3;
  localparam int DEF_PLAY_SEC    = 60;
  localparam int DEF_TIMESUP_SEC = 3;
  localparam int DEF_LEADER_SEC  = 10;
  localparam int DEF_SEC_W       = 7;

  function automatic screen_sel_t sel_decode(input screen_state_t s);
    unique case (s)
      LOGO:        return SEL_LOGO;
      GET_READY:   return SEL_GET_READY;
      PLAY:        return SEL_PLAY;
      TIMES_UP:    return SEL_TIMES_UP;
      LEADERBOARD: return SEL_LEADERBOARD;
      default:     return SEL_LOGO;
    endcase
  endfunction

  // The screens form a fixed ring; only the exit condition differs per state.
  function automatic screen_state_t next_screen(input screen_state_t s);
    unique case (s)
      LOGO:        return GET_READY;
      GET_READY:   return PLAY;
      PLAY:        return TIMES_UP;
      TIMES_UP:    return LEADERBOARD;
      LEADERBOARD: return LOGO;
      default:     return LOGO;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 and pulses tick for one clock at
// the terminal count. clr restarts the second; en low freezes the count.
module sec_tick_gen
  import game_screen_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && !clr && (count == TERM);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours regardless of block evaluation order.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == TERM) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_screen_sequencer.sv
// Game-flow FSM driving the VGA screen selects; screens change only at frame
// start. Optional feature macro: GAME_PAUSE_EN (adds pause port for PLAY).
module game_screen_sequencer
  import game_screen_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int READY_SEC   = DEF_READY_SEC,
  parameter int PLAY_SEC    = DEF_PLAY_SEC,
  parameter int TIMESUP_SEC = DEF_TIMESUP_SEC,
  parameter int LEADER_SEC  = DEF_LEADER_SEC,
  parameter int SEC_W       = DEF_SEC_W
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic             iVS,
  input  logic             start,
  input  logic             two_player_sel,
`ifdef GAME_PAUSE_EN
  input  logic             pause,
`endif
  output logic             logo,
  output logic             get_ready,
  output logic             play_active,
  output logic             times_up,
  output logic             leaderboard,
  output logic             two_player_mode,
  output logic [SEC_W-1:0] sec_left
);

  screen_state_t state;
  screen_sel_t   sel_q;

  logic       vs_q;
  logic       frame_start;
  logic [2:0] start_sync;   // [1:0] synchronizer, [2] edge-detect history
  logic       start_rise;
  logic       start_pend;
  logic       timer_hold;
  logic       sec_tick;
  logic       expired;
  logic       advance;

  function automatic logic [SEC_W-1:0] load_value(input screen_state_t s);
    unique case (s)
      GET_READY:   return SEC_W'(READY_SEC);
      PLAY:        return SEC_W'(PLAY_SEC);
      TIMES_UP:    return SEC_W'(TIMESUP_SEC);
      LEADERBOARD: return SEC_W'(LEADER_SEC);
      default:     return '0;
    endcase
  endfunction

  // vs_q resets low so a reset released during vsync does not fake an edge.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q        <= 1'b0;
      frame_start <= 1'b0;
      start_sync  <= '0;
      start_pend  <= 1'b0;
    end else begin
      vs_q        <= iVS;
      frame_start <= vs_q && !iVS;
      start_sync  <= {start_sync[1:0], start};
      if (frame_start) begin
        start_pend <= 1'b0;
      end else if (start_rise) begin
        start_pend <= 1'b1;
      end
    end
  end

  assign start_rise = start_sync[1] && !start_sync[2];

`ifdef GAME_PAUSE_EN
  logic [1:0] pause_sync;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pause_sync <= '0;
    end else begin
      pause_sync <= {pause_sync[0], pause};
    end
  end

  assign timer_hold = pause_sync[1] && (state == PLAY);
`else
  assign timer_hold = 1'b0;
`endif

  // Expiry looks at the pre-edge sec_left, so a coincident tick that reaches
  // zero only takes effect at the following frame start.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    expired = (sec_left == '0);
    advance = 1'b0;
    if (frame_start) begin
      unique case (state)
        LOGO:        advance = start_pend;
        LEADERBOARD: advance = start_pend || expired;
        default:     advance = expired && !timer_hold;
      endcase
    end
  end

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick_gen (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .clr      (advance),
    .en       (!timer_hold),
    .tick     (sec_tick)
  );

  // Selects decode the current state, so they follow a transition by one clock.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state           <= LOGO;
      sel_q           <= SEL_LOGO;
      sec_left        <= '0;
      two_player_mode <= 1'b0;
    end else begin
      sel_q <= sel_decode(state);
      if (advance) begin
        state    <= next_screen(state);
        sec_left <= load_value(next_screen(state));
        if (state == LOGO) begin
          two_player_mode <= two_player_sel;
        end
      end else if (sec_tick && (sec_left != '0)) begin
        sec_left <= sec_left - SEC_W'(1);
      end
    end
  end

  assign {leaderboard, times_up, play_active, get_ready, logo} = sel_q;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Self-checking bench for game_screen_sequencer: a seconds-based reference
// model compared every cycle, plus hand-computed timing expectations.
module tb_game_screen_sequencer;

  localparam int CLK_HZ = 10;
  localparam int SEC_W  = 7;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_BUILD = 1'b1;
`else
  localparam bit PAUSE_BUILD = 1'b0;
`endif

  localparam int S_LOGO = 0, S_READY = 1, S_PLAY = 2, S_TUP = 3, S_LEAD = 4;
  localparam int DUR [5] = '{0, 2, 3, 1, 2};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             iVS;
  logic             start;
  logic             two_player_sel;
  logic             pause_b;
  logic             logo, get_ready, play_active, times_up, leaderboard;
  logic             two_player_mode;
  logic [SEC_W-1:0] sec_left;
  logic [4:0]       sel;

  assign sel = {leaderboard, times_up, play_active, get_ready, logo};

  game_screen_sequencer #(
    .CLK_HZ      (CLK_HZ),
    .READY_SEC   (2),
    .PLAY_SEC    (3),
    .TIMESUP_SEC (1),
    .LEADER_SEC  (2),
    .SEC_W       (SEC_W)
  ) dut (
    .iVGA_CLK        (clk),
    .iRST_n          (rst_n),
    .iVS             (iVS),
    .start           (start),
    .two_player_sel  (two_player_sel),
`ifdef GAME_PAUSE_EN
    .pause           (pause_b),
`endif
    .logo            (logo),
    .get_ready       (get_ready),
    .play_active     (play_active),
    .times_up        (times_up),
    .leaderboard     (leaderboard),
    .two_player_mode (two_player_mode),
    .sec_left        (sec_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_len = 40;
  int vs_cnt    = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Frame generator: frame_len clocks per frame, vsync low for 4 clocks.
  initial begin
    iVS = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (vs_cnt >= frame_len - 1) vs_cnt = 0;
      else vs_cnt++;
      iVS = !(vs_cnt < 4);
    end
  end

  // Reference model: screen order, whole-second countdown from entry time
  // (paused clocks excluded), decisions taken only at frame starts.
  int m_state, m_shown, m_active, m_load, m_sec;
  bit m_mode, m_pend;
  bit [1:0] vs_h;
  bit [2:0] st_h;
  bit [1:0] ps_h;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = S_LOGO; m_shown = S_LOGO; m_active = 0; m_load = 0; m_sec = 0;
      m_mode = 1'b0; m_pend = 1'b0; vs_h = '0; st_h = '0; ps_h = '0;
    end else begin
      bit fs, rise, frozen, adv;
      fs     = vs_h[1] && !vs_h[0];
      rise   = st_h[1] && !st_h[2];
      frozen = PAUSE_BUILD && ps_h[1] && (m_state == S_PLAY);
      adv    = 1'b0;
      if (fs) begin
        if (m_state == S_LOGO)      adv = m_pend;
        else if (m_state == S_LEAD) adv = m_pend || (m_sec == 0);
        else                        adv = (m_sec == 0) && !frozen;
      end
      m_shown = m_state;
      if (adv) begin
        if (m_state == S_LOGO) m_mode = two_player_sel;
        m_state  = (m_state + 1) % 5;
        m_load   = DUR[m_state];
        m_active = 0;
        m_sec    = m_load;
      end else begin
        if (!frozen) m_active++;
        m_sec = m_load - m_active / CLK_HZ;
        if (m_sec < 0) m_sec = 0;
      end
      m_pend = fs ? 1'b0 : (m_pend | rise);
      vs_h = {vs_h[0], iVS};
      st_h = {st_h[1:0], start};
      ps_h = {ps_h[0], pause_b};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot", $countones(sel), 1);
      check("sel", sel, 32'(1) << m_shown);
      check("sec_left", sec_left, m_sec);
      check("mode", two_player_mode, m_mode);
    end
  end

  task automatic wait_level(input int idx, input bit val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (sel[idx] == val) begin
        at = cyc;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_sel%0d: select still %0d after %0d clocks, required %0d", idx, !val, budget, val);
  endtask

  // Press start well inside a frame so the pending flag is never set on a
  // frame-start cycle.
  task automatic press_start();
    @(negedge iVS);
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
  endtask

  int t_a, t_b;
  int t0;

  initial begin
    rst_n = 1'b0; start = 1'b0; two_player_sel = 1'b0; pause_b = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle for 10 frames without start
    repeat (400) @(posedge clk);
    #1;
    check("idle_logo", logo, 1);
    check("idle_sec", sec_left, 0);
    check("idle_sel", sel, 5'b00001);

    // Round 1: 40-clock frames, two-player
    two_player_sel = 1'b1;
    press_start();
    wait_level(1, 1'b1, 200, t_a);
    check("gr_sec", sec_left, 2);
    check("gr_mode", two_player_mode, 1);
    two_player_sel = 1'b0;
    wait_level(2, 1'b1, 200, t_b);
    check("gr_len", t_b - t_a, 40);
    t_a = t_b;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    check("pl_mode_held", two_player_mode, 1);
    wait_level(3, 1'b1, 200, t_b);
    check("pl_len", t_b - t_a, 40);
    check("after_play", sel, 5'b01000);
    t_a = t_b;
    wait_level(4, 1'b1, 200, t_b);
    check("tu_len", t_b - t_a, 40);
    t_a = t_b;
    wait_level(0, 1'b1, 200, t_b);
    check("lb_len", t_b - t_a, 40);

    // Round 2: 20-clock frames; tick meets frame start, early leaderboard exit
    frame_len = 20;
    repeat (60) @(posedge clk);
    #1 two_player_sel = 1'b0;
    press_start();
    wait_level(1, 1'b1, 200, t_a);
    check("r2_mode", two_player_mode, 0);
    repeat (20) @(posedge clk);
    #1;
    check("coinc_sec", sec_left, 0);
    check("coinc_hold", get_ready, 1);
    wait_level(1, 1'b0, 200, t_b);
    check("r2_gr_len", t_b - t_a, 40);
    wait_level(4, 1'b1, 400, t_a);
    check("lb_sec", sec_left, 2);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    wait_level(0, 1'b1, 200, t_b);
    check("lb_start_len", t_b - t_a, 20);

`ifdef GAME_PAUSE_EN
    // Round 3: pause ignored in GET_READY, freezes the PLAY timer
    frame_len = 40;
    repeat (100) @(posedge clk);
    #1 two_player_sel = 1'b1;
    press_start();
    wait_level(1, 1'b1, 200, t_a);
    repeat (2) @(posedge clk);
    #1 pause_b = 1'b1;
    repeat (25) @(posedge clk);
    #1 pause_b = 1'b0;
    wait_level(2, 1'b1, 200, t_b);
    check("gr_pause_len", t_b - t_a, 40);
    t_a = t_b;
    repeat (12) @(posedge clk);
    #1 pause_b = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("pause_sec_frozen", sec_left, 2);
    pause_b = 1'b0;
    t0 = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sec_left == 0) begin
        t0 = cyc - t_a;
        break;
      end
    end
    check("pause_zero_time", t0, 54);
    wait_level(3, 1'b1, 200, t_b);
    check("pause_pl_len", t_b - t_a, 80);
    wait_level(0, 1'b1, 400, t_b);
`endif

    // Round 4: asynchronous reset in the middle of PLAY
    frame_len = 40;
    repeat (50) @(posedge clk);
    #1 two_player_sel = 1'b1;
    press_start();
    wait_level(2, 1'b1, 300, t_a);
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_mode", two_player_mode, 1);
    check("pre_rst_play", play_active, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_logo", logo, 1);
    check("rst_play", play_active, 0);
    check("rst_sec", sec_left, 0);
    check("rst_mode", two_player_mode, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("post_rst_logo", logo, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
